// File: rtl/pri_enc_pkg.sv
// pri_enc_pkg: shared FSM state type and priority-pick helper for the 8-to-3 encoder.
package pri_enc_pkg;

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    localparam int MAX_IN = 16;
    localparam int MAX_W  = 4;

    // Descending search from start, wrapping modulo n; returns start when nothing is set.
    function automatic logic [MAX_W-1:0] pri_pick(input logic [MAX_IN-1:0] pend,
                                                  input logic [MAX_W-1:0]  start,
                                                  input int                n);
        logic [MAX_W-1:0] r;
        logic             found;
        int               idx;
        r     = start;
        found = 1'b0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (i < n) begin
                idx = (int'(start) + n - i) % n;
                if (!found && pend[idx]) begin
                    r     = MAX_W'(idx);
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pri_enc_if.sv
// pri_enc_if: active-low code output with valid/ready handshake (master = encoder).
interface pri_enc_if #(parameter int CODE_W = 3);

    logic [CODE_W-1:0] A_n;
    logic              GS_n;
    logic              out_valid;
    logic              out_ready;

    modport master (output A_n, GS_n, out_valid, input out_ready);
    modport slave  (input A_n, GS_n, out_valid, output out_ready);

endinterface

// File: rtl/pri_enc_sync.sv
// pri_enc_sync: per-line synchroniser chain resetting to inactive (1); STAGES=0 passes through.
module pri_enc_sync #(
    parameter int N_IN   = 8,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] d,
    output logic [N_IN-1:0] q
);

    generate
        if (STAGES == 0) begin : g_pass
            assign q = d;
        end else begin : g_sync
            logic [N_IN-1:0] st [STAGES];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) st[i] <= '1;
                end else begin
                    st[0] <= d;
                    for (int i = 1; i < STAGES; i++) st[i] <= st[i-1];
                end
            end
            assign q = st[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/pri_encoder_8to3_seq.sv
// pri_encoder_8to3_seq: registered 74LS148-style priority encoder with sticky pending and valid/ready output.
// Define PRI_ENC_ROTATE_EN for round-robin priority (last_grant register); fixed priority otherwise.
module pri_encoder_8to3_seq
    import pri_enc_pkg::*;
#(
    parameter  int N_IN        = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int CODE_W      = $clog2(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] I_n,
    input  logic            EI_n,
    output logic            EO_n,
    pri_enc_if.master       bus
);

    logic [N_IN-1:0]   i_sync;
    logic [N_IN-1:0]   pending;
    logic [N_IN-1:0]   clr_mask;
    logic [CODE_W-1:0] a_q, a_nxt, win, start;
    logic              valid_q, valid_nxt, accept, grant;
    state_t            state, state_nxt;

    pri_enc_sync #(.N_IN(N_IN), .STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (I_n),
        .q   (i_sync)
    );

`ifdef PRI_ENC_ROTATE_EN
    logic [CODE_W-1:0] last_grant;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant <= '0;
        else if (accept) last_grant <= ~a_q;
    end
    assign start = last_grant - 1'b1;
`else
    assign start = CODE_W'(N_IN - 1);
`endif

    assign win      = CODE_W'(pri_pick(MAX_IN'(pending), MAX_W'(start), N_IN));
    assign accept   = valid_q & bus.out_ready;
    assign grant    = (state == ST_IDLE) & ~EI_n & (|pending);
    // The granted index is recovered from the held code, so no separate index register is needed.
    assign clr_mask = accept ? (N_IN'(1) << ~a_q) : '0;

    always_comb begin
        state_nxt = grant ? ST_HOLD : accept ? ST_IDLE : state;
        a_nxt     = grant ? ~win : accept ? '1 : a_q;
        valid_nxt = grant ? 1'b1 : accept ? 1'b0 : valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_q     <= '1;
            valid_q <= 1'b0;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            a_q     <= a_nxt;
            valid_q <= valid_nxt;
            pending <= (pending & ~clr_mask) | ~i_sync;
        end
    end

    assign bus.A_n       = a_q;
    assign bus.out_valid = valid_q;
    assign bus.GS_n      = ~valid_q;
    assign EO_n          = ~(~EI_n & ~(|pending) & (state == ST_IDLE));

endmodule
